mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, address width.
REQ-002 Parameter DATA_W, default 64, data width.
REQ-003 Parameter STARVE_MAX, default 4, maximum consecutive data-side grants while fetch is waiting; legal range 1..15.
REQ-004 Port: clk  in  1  single clock; all state on rising edge.
REQ-005 Port: rstn  in  1  asynchronous, active-low reset.
REQ-006 Ports: if_req in 1 / if_addr in ADDR_W. Fetch read request; held stable until granted.
REQ-007 Ports: if_grant out 1 / if_rvalid out 1 / if_rdata out DATA_W. Fetch grant pulse and read return.
REQ-008 Ports: dm_req in 1 / dm_we in 1 / dm_addr in ADDR_W / dm_wdata in DATA_W. Load/store request; held stable until granted.
REQ-009 Ports: dm_grant out 1 / dm_rvalid out 1 / dm_rdata out DATA_W. Data grant pulse and load return.
REQ-010 Ports: mem_req out 1 / mem_we out 1 / mem_addr out ADDR_W / mem_wdata out DATA_W. Shared memory port request.
REQ-011 Ports: mem_ready in 1 / mem_rvalid in 1 / mem_rdata in DATA_W. Memory accept and read return.
REQ-012 Port: stall_pc out 1. Combinational; high when if_req=1 and if_grant=0, or when dm_req=1 and dm_grant=0.

Function
REQ-013 The FSM SHALL have three states: IDLE, RD_WAIT (read outstanding) and WR_DONE (write accepted, one-cycle retire); at most one transaction SHALL be outstanding.
REQ-014 In IDLE, mem_req SHALL equal if_req|dm_req; address, we and wdata SHALL come from the selected requester.
REQ-015 Selection: data-side wins, unless if_req=1 and starve_cnt==STARVE_MAX, in which case fetch wins.
REQ-016 A grant occurs when state==IDLE, mem_req=1 and mem_ready=1; the selected requester's grant SHALL pulse high for exactly that cycle, and the other grant SHALL stay low.
REQ-017 A granted read (fetch, or data with dm_we=0) SHALL move the FSM to RD_WAIT and latch owner∈{IF,DM}; a granted write SHALL move it to WR_DONE.
REQ-018 In RD_WAIT, mem_req SHALL be 0; on mem_rvalid=1, the owner's rvalid SHALL pulse for that cycle with rdata=mem_rdata, and the FSM SHALL return to IDLE.
REQ-019 A new grant SHALL NOT occur in the cycle mem_rvalid returns; minimum read-to-next-grant spacing is 1 cycle.
REQ-020 WR_DONE SHALL return to IDLE unconditionally after 1 cycle, with mem_req=0.
REQ-021 starve_cnt (4 bits): +1 on each data grant while if_req=1; cleared on any fetch grant, or on any grant while if_req=0; saturates at STARVE_MAX.
REQ-022 mem_rvalid asserted outside RD_WAIT SHALL be ignored, and no rvalid output SHALL pulse.
REQ-023 if_rdata/dm_rdata SHALL be driven from mem_rdata at all times; only rvalid qualifies them.
REQ-024 Requests that drop before a grant SHALL be dropped silently, with no state change.

Reset
REQ-025 On rstn=0 (asynchronous, including mid-transaction): state=IDLE, owner=IF, starve_cnt=0, all grant and rvalid outputs 0; an in-flight read's later mem_rvalid SHALL be ignored per REQ-022.
REQ-026 After reset release, the first grant SHALL be possible in the first cycle with rstn=1.

Verification
REQ-027 Single fetch: if_req=1, addr=0x1000, mem_ready=1; mem_rvalid returned 2 cycles later with data 0xDEAD -> if_grant at cycle 0, if_rvalid=1 with if_rdata=0xDEAD at cycle 2, stall_pc=0 from cycle 1.
REQ-028 Contention: if_req and dm_req (load) both asserted at reset release -> dm_grant first; if_grant only after dm_rvalid plus 1 cycle; stall_pc=1 throughout the wait.
REQ-029 Starvation: if_req held while a back-to-back store stream runs on dm_req, STARVE_MAX=4 -> exactly 4 dm_grants, then if_grant, then starve_cnt=0.
REQ-030 Store: dm_req=1, dm_we=1, wdata=0x55 -> mem_we=1 and mem_wdata=0x55 at the grant, no dm_rvalid, next grant possible 2 cycles after the write grant.
REQ-031 Backpressure: mem_ready=0 for 3 cycles with dm_req=1 -> no grant, mem_req and mem_addr stable, stall_pc=1; grant in the cycle mem_ready=1.
REQ-032 Reset mid-read: rstn pulsed low during RD_WAIT, then mem_rvalid=1 -> no rvalid output, state IDLE, starve_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter for instruction-fetch and load/store requesters.
// One transaction in flight at a time; the data side has priority unless
// fetch has been passed over STARVE_MAX times in a row.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 64,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned STARVE_MAX = 4    // legal range 1..15
) (
   input  logic              clk,
   input  logic              rstn,
   // fetch side
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_grant,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   // load/store side
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_grant,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   // shared memory port
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   // pipeline stall
   output logic              stall_pc
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_DONE} state_e;
   typedef enum logic {OWN_IF, OWN_DM} owner_e;

   state_e           state_q, state_d;
   owner_e           owner_q, owner_d;
   logic [CNT_W-1:0] starve_q, starve_d;

   logic             starved;
   logic             sel_if;

   // Fetch is forced through once it has waited STARVE_MAX data grants.
   assign starved = (starve_q == CNT_W'(STARVE_MAX));
   assign sel_if  = if_req & (starved | ~dm_req);

   // Read data is passed straight through; rvalid alone qualifies it.
   assign if_rdata = mem_rdata;
   assign dm_rdata = mem_rdata;

   // Any requester not granted this cycle holds the pipeline.
   assign stall_pc = (if_req & ~if_grant) | (dm_req & ~dm_grant);

   // State, owner and starvation counter registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         owner_q  <= OWN_IF;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end

   // Next-state, arbitration and memory-port drive.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      starve_d  = starve_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = sel_if ? if_addr : dm_addr;
      mem_wdata = sel_if ? '0 : dm_wdata;
      if_grant  = 1'b0;
      dm_grant  = 1'b0;
      if_rvalid = 1'b0;
      dm_rvalid = 1'b0;

      case (state_q)
         IDLE: begin
            mem_req = if_req | dm_req;
            mem_we  = ~sel_if & dm_req & dm_we;
            // grants are held off while reset is asserted
            if (mem_req && mem_ready && rstn) begin
               if (sel_if) begin
                  if_grant = 1'b1;
                  owner_d  = OWN_IF;
                  state_d  = RD_WAIT;
                  starve_d = '0;
               end else begin
                  dm_grant = 1'b1;
                  owner_d  = OWN_DM;
                  state_d  = dm_we ? WR_DONE : RD_WAIT;
                  if (!if_req) begin
                     starve_d = '0;
                  end else if (!starved) begin
                     starve_d = starve_q + CNT_W'(1);
                  end
               end
            end
         end
         RD_WAIT: begin
            if (mem_rvalid) begin
               if_rvalid = (owner_q == OWN_IF);
               dm_rvalid = (owner_q == OWN_DM);
               state_d   = IDLE;
            end
         end
         WR_DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle vector table plus a
// read-return scoreboard and a hand-written reset-during-read sequence.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam logic [AW-1:0] IA = 64'h1000;
   localparam logic [AW-1:0] DA = 64'h2000;
   localparam logic [DW-1:0] WD = 64'h55;
   localparam int NV = 42;

   logic          clk = 1'b0;
   logic          rstn;
   logic          if_req, if_grant, if_rvalid;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          dm_req, dm_we, dm_grant, dm_rvalid;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata, dm_rdata;
   logic          mem_req, mem_we, mem_ready, mem_rvalid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          stall_pc;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
      .clk(clk), .rstn(rstn),
      .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_grant(dm_grant), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .stall_pc(stall_pc)
   );

   // inputs {rstn,if_req,dm_req,dm_we,mem_ready,mem_rvalid};
   // expected {if_grant,dm_grant,mem_req,mem_we,if_rvalid,dm_rvalid,stall_pc}
   typedef struct {
      logic [5:0]    in;
      logic [DW-1:0] rdata;
      logic [6:0]    exp;
      logic [AW-1:0] addr;
   } vec_t;

   typedef struct {
      logic          own_dm;
      logic [DW-1:0] data;
   } rv_t;

   vec_t vt [NV];
   rv_t  sbq [$];

   function automatic vec_t mk(input logic [5:0] in, input logic [DW-1:0] rd,
                               input logic [6:0] ex, input logic [AW-1:0] ad);
      vec_t v;
      v.in = in; v.rdata = rd; v.exp = ex; v.addr = ad;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [5:0] in, input logic [DW-1:0] rd);
      {rstn, if_req, dm_req, dm_we, mem_ready, mem_rvalid} = in;
      mem_rdata = rd;
   endtask

   // Pop the expected return whenever the DUT signals read data.
   task automatic sample_sb(input string tag);
      rv_t e;
      if (if_rvalid || dm_rvalid) begin
         if (sbq.size() == 0) begin
            chk({tag, " unexpected rvalid"}, {if_rvalid, dm_rvalid}, 64'd0);
         end else begin
            e = sbq.pop_front();
            chk({tag, " sb owner"}, 64'(dm_rvalid), 64'(e.own_dm));
            chk({tag, " sb data"}, dm_rvalid ? dm_rdata : if_rdata, e.data);
         end
      end
   endtask

   initial begin
      rv_t r;
      if_addr = IA; dm_addr = DA; dm_wdata = WD;
      drive(6'b000000, '0);
      repeat (2) @(posedge clk);
      #1;

      vt[0]  = mk(6'b000000, 64'h0,    7'b0000000, 64'h0);  // in reset
      vt[1]  = mk(6'b110010, 64'h0,    7'b1010000, IA);     // single fetch grant
      vt[2]  = mk(6'b100010, 64'h0,    7'b0000000, 64'h0);
      vt[3]  = mk(6'b100001, 64'hDEAD, 7'b0000100, 64'h0);  // fetch return
      vt[4]  = mk(6'b100001, 64'hBAD,  7'b0000000, 64'h0);  // stray rvalid in IDLE
      vt[5]  = mk(6'b101110, 64'h0,    7'b0111000, DA);     // store grant
      vt[6]  = mk(6'b101110, 64'h0,    7'b0000001, 64'h0);  // WR_DONE
      vt[7]  = mk(6'b101110, 64'h0,    7'b0111000, DA);     // 2 cycles later
      vt[8]  = mk(6'b100000, 64'h0,    7'b0000000, 64'h0);
      vt[9]  = mk(6'b101000, 64'h0,    7'b0010001, DA);     // backpressure
      vt[10] = mk(6'b101000, 64'h0,    7'b0010001, DA);
      vt[11] = mk(6'b101000, 64'h0,    7'b0010001, DA);
      vt[12] = mk(6'b101010, 64'h0,    7'b0110000, DA);     // ready -> grant
      vt[13] = mk(6'b100000, 64'h0,    7'b0000000, 64'h0);
      vt[14] = mk(6'b100001, 64'h1234, 7'b0000010, 64'h0);  // load return
      vt[15] = mk(6'b100000, 64'h0,    7'b0000000, 64'h0);
      vt[16] = mk(6'b011010, 64'h0,    7'b0010001, DA);     // both req in reset
      vt[17] = mk(6'b111010, 64'h0,    7'b0110001, DA);     // first cycle out: dm wins
      vt[18] = mk(6'b110000, 64'h0,    7'b0000001, 64'h0);
      vt[19] = mk(6'b110001, 64'hCAFE, 7'b0000011, 64'h0);  // no grant on return
      vt[20] = mk(6'b110010, 64'h0,    7'b1010000, IA);     // fetch one cycle later
      vt[21] = mk(6'b100000, 64'h0,    7'b0000000, 64'h0);
      vt[22] = mk(6'b100001, 64'hF00D, 7'b0000100, 64'h0);
      vt[23] = mk(6'b111110, 64'h0,    7'b0111001, DA);     // starvation stream
      vt[24] = mk(6'b111110, 64'h0,    7'b0000001, 64'h0);
      vt[25] = mk(6'b111110, 64'h0,    7'b0111001, DA);
      vt[26] = mk(6'b111110, 64'h0,    7'b0000001, 64'h0);
      vt[27] = mk(6'b111110, 64'h0,    7'b0111001, DA);
      vt[28] = mk(6'b111110, 64'h0,    7'b0000001, 64'h0);
      vt[29] = mk(6'b111110, 64'h0,    7'b0111001, DA);
      vt[30] = mk(6'b111110, 64'h0,    7'b0000001, 64'h0);
      vt[31] = mk(6'b111110, 64'h0,    7'b1010001, IA);     // fetch forced through
      vt[32] = mk(6'b101100, 64'h0,    7'b0000001, 64'h0);
      vt[33] = mk(6'b101101, 64'hABCD, 7'b0000101, 64'h0);
      vt[34] = mk(6'b111110, 64'h0,    7'b0111001, DA);     // counter restarted
      vt[35] = mk(6'b100000, 64'h0,    7'b0000000, 64'h0);
      vt[36] = mk(6'b100000, 64'h0,    7'b0000000, 64'h0);
      vt[37] = mk(6'b110000, 64'h0,    7'b0010001, IA);     // request dropped
      vt[38] = mk(6'b100000, 64'h0,    7'b0000000, 64'h0);
      vt[39] = mk(6'b101010, 64'h0,    7'b0110000, DA);     // still IDLE
      vt[40] = mk(6'b100000, 64'h0,    7'b0000000, 64'h0);
      vt[41] = mk(6'b100001, 64'h77,   7'b0000010, 64'h0);

      for (int i = 0; i < NV; i++) begin
         string t;
         t = $sformatf("v%0d", i);
         drive(vt[i].in, vt[i].rdata);
         if (vt[i].exp[2]) begin r.own_dm = 1'b0; r.data = vt[i].rdata; sbq.push_back(r); end
         if (vt[i].exp[1]) begin r.own_dm = 1'b1; r.data = vt[i].rdata; sbq.push_back(r); end
         @(negedge clk);
         chk({t, " if_grant"},  64'(if_grant),  64'(vt[i].exp[6]));
         chk({t, " dm_grant"},  64'(dm_grant),  64'(vt[i].exp[5]));
         chk({t, " mem_req"},   64'(mem_req),   64'(vt[i].exp[4]));
         chk({t, " mem_we"},    64'(mem_we),    64'(vt[i].exp[3]));
         chk({t, " if_rvalid"}, 64'(if_rvalid), 64'(vt[i].exp[2]));
         chk({t, " dm_rvalid"}, 64'(dm_rvalid), 64'(vt[i].exp[1]));
         chk({t, " stall_pc"},  64'(stall_pc),  64'(vt[i].exp[0]));
         chk({t, " if_rdata"},  if_rdata, vt[i].rdata);
         if (vt[i].exp[4]) chk({t, " mem_addr"}, mem_addr, vt[i].addr);
         if (vt[i].exp[3]) chk({t, " mem_wdata"}, mem_wdata, WD);
         sample_sb(t);
         @(posedge clk);
         #1;
      end

      // Reset pulsed during an outstanding load; its late return must vanish.
      drive(6'b111010, '0);
      @(negedge clk);
      chk("mr grant", 64'(dm_grant), 64'd1);
      @(posedge clk);
      #1;
      chk("mr starve before", 64'(dut.starve_q), 64'd1);
      drive(6'b100000, '0);
      #2 rstn = 1'b0;
      #2 rstn = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 64'h99;
      @(negedge clk);
      chk("mr if_rvalid", 64'(if_rvalid), 64'd0);
      chk("mr dm_rvalid", 64'(dm_rvalid), 64'd0);
      chk("mr state", 64'(dut.state_q), 64'd0);
      chk("mr starve", 64'(dut.starve_q), 64'd0);
      sample_sb("mr");
      @(posedge clk);
      #1;
      drive(6'b101010, '0);
      @(negedge clk);
      chk("mr regrant", 64'(dm_grant), 64'd1);
      @(posedge clk);
      #1;
      drive(6'b100001, 64'h4242);
      r.own_dm = 1'b1; r.data = 64'h4242; sbq.push_back(r);
      @(negedge clk);
      chk("mr final rvalid", 64'(dm_rvalid), 64'd1);
      sample_sb("mr final");
      @(posedge clk);
      #1;
      drive(6'b100000, '0);

      chk("sb empty", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
